irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Memory-mapped interrupt controller directly upstream of the MIPS core's INT[5:0] input.
//  - Synchronises external requests, then latches edge-type requests as pending.
//  - Applies a software mask and drives the masked pending vector onto INT.
//  - The handler reads the highest-priority source ID, then clears it by write-1-to-clear.
//  - Sits on the data-memory bus beside data memory; the address decoder supplies sel.
// PARAMETERS
//  N_SRC   6   number of interrupt sources; equals core INT width; legal range 1..16
// PORTS
//  clk      in   1      system clock; all state updates on the rising edge
//  rst      in   1      asynchronous, active-low reset
//  irq_in   in   N_SRC  external interrupt requests; asynchronous to clk
//  sel      in   1      bus select from address decode (address in controller window)
//  addr     in   4      byte offset within window; bits [3:2] select register, [1:0] ignored
//  we       in   1      write strobe (core we_dm); acts only when sel=1
//  wdata    in   32     write data (core wd_dm)
//  rdata    out  32     read data; combinational, valid in the same cycle as sel
//  int_out  out  N_SRC  masked pending vector, connected to core INT
// BEHAVIOUR
//  Reset (rst=0, async):
//   - sync stages, prev, PEND, MASK and EDGE all clear to 0.
//   - int_out=0 and rdata=0 immediately, without waiting for a clock edge.
//   - A reset mid-operation discards all pending requests.
//  Synchroniser, per source: s1<=irq_in; s2<=s1; prev<=s2.
//  Pending update, per bit i:
//   - Edge mode (EDGE[i]=1): set when s2&~prev; clear on W1C write to offset 0x0.
//   - Edge mode, set and clear in the same cycle: set wins (pend stays 1).
//   - Level mode (EDGE[i]=0): PEND[i]<=s2. W1C writes are ignored.
//  Latency: irq_in rises ahead of edge e1 -> s1@e1, s2@e2, PEND@e3.
//   int_out bit is high after e3 (3 cycles).
//  int_out = PEND & MASK. Combinational from flops only, so it is glitch-free.
//  Register map (addr[3:2]):
//   0x0 PEND  read: {0,PEND}; write: W1C mask applied to PEND
//   0x4 MASK  read/write: N_SRC LSBs; upper bits read 0
//   0x8 EDGE  read/write: 1=rising-edge latched, 0=level
//   0xC ID    read-only: {valid@bit31, 0, id[3:0]}
//             id = lowest-index set bit of PEND&MASK (bit 0 = highest priority)
//             valid=0 and id=0 when none is set; writes ignored
//  Bus rules:
//   - Writes take effect at the next rising edge.
//   - A read in the same cycle returns the old value.
//   - rdata=0 whenever sel=0.
//   - Writes to unimplemented bits have no effect.
//  Masking does not clear PEND. An unmasked pending bit reasserts int_out the same cycle MASK updates.
//  No other state; no FSM beyond the per-bit pending flag.
// STRUCTURE
//  Shared package irq_pkg:
//   - Register offsets IRQ_PEND=2'd0, IRQ_MASK=2'd1, IRQ_EDGE=2'd2, IRQ_ID=2'd3.
//   - ID valid bit position IRQ_ID_VALID=31.
//  Sub-module irq_sync, instantiated once per source:
//   - 2-flop synchroniser plus prev flop, async active-low reset.
//   - Outputs: level (s2) and rise (s2&~prev).
//  Top level holds PEND/MASK/EDGE, the priority encoder and the read mux.
// TESTING
//  1 Reset: hold rst=0 with irq_in=6'h3F -> int_out=0 and all reads 0. Release -> int_out stays 0 (MASK=0).
//  2 Edge latch: MASK=0x3F, EDGE=0x3F, pulse irq_in[2] for 1 cycle (aligned to clk)
//    -> int_out=6'h04 exactly 3 edges later; ID read=0x80000002.
//  3 Priority/clear: irq_in[1] and [4] pending
//    -> ID=0x80000001; write 0x02 to 0x0 -> ID=0x80000004; write 0x10 -> ID=0, int_out=0.
//  4 Set/clear collision: W1C of bit 3 in the same cycle as a new rising edge on bit 3
//    -> PEND[3] stays 1.
//  5 Level mode: EDGE=0, MASK=0x01, hold irq_in[0]=1 -> int_out[0]=1.
//    W1C 0x01 -> stays 1. Drop irq_in[0] -> int_out[0]=0 three edges later.
//  6 Mask: pending bit 5 with MASK=0 -> int_out=0 and PEND read=0x20. Write MASK=0x20 -> int_out=6'h20 next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the register offsets (addr[3:2]), the ID valid-bit position and the
// priority encoder that turns the active vector into a source ID.
package irq_pkg;

    localparam logic [1:0] IRQ_PEND = 2'd0;
    localparam logic [1:0] IRQ_MASK = 2'd1;
    localparam logic [1:0] IRQ_EDGE = 2'd2;
    localparam logic [1:0] IRQ_ID   = 2'd3;

    localparam int IRQ_ID_VALID = 31;
    localparam int IRQ_MAX_SRC  = 16;

    // Lowest set index wins: scan from the top so the last hit is the lowest bit.
    function automatic logic [3:0] irq_prio_id(input logic [IRQ_MAX_SRC-1:0] act);
        logic [3:0] id;
        id = '0;
        for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
            if (act[i]) id = 4'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-source request synchroniser.
// Two flops bring the asynchronous request into clk, a third holds the
// previous synchronised value so a rising edge can be detected.
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   din   in  raw external request
//   level out synchronised request (second stage)
//   rise  out one-cycle pulse when the synchronised request goes 0 -> 1
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding the core INT inputs.
// Synchronises requests, latches edge-type requests as pending, masks them
// and reports the highest-priority active source through an ID register.
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   irq_in  in  external requests, asynchronous to clk
//   sel     in  bus select from the address decoder
//   addr    in  byte offset; [3:2] picks the register
//   we      in  write strobe, qualified by sel
//   wdata   in  write data
//   rdata   out combinational read data, zero when sel is low
//   int_out out PEND & MASK, driven from flops only
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             sel,
    input  logic [3:0]       addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [N_SRC-1:0] int_out
);

    logic [N_SRC-1:0] level;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] edge_mode;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] active;
    logic [IRQ_MAX_SRC-1:0] act_wide;
    logic [3:0]       id;
    logic             id_valid;
    logic             bus_wr;
    logic             unused_bits;

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        irq_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (irq_in[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    assign bus_wr = sel & we;
    assign clr    = (bus_wr && addr[3:2] == IRQ_PEND) ? wdata[N_SRC-1:0] : '0;

    // Edge bits: a new rise beats a simultaneous W1C. Level bits just follow s2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= (edge_mode & (rise | (pend & ~clr))) | (~edge_mode & level);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask      <= '0;
            edge_mode <= '0;
        end else if (bus_wr) begin
            if (addr[3:2] == IRQ_MASK) mask      <= wdata[N_SRC-1:0];
            if (addr[3:2] == IRQ_EDGE) edge_mode <= wdata[N_SRC-1:0];
        end
    end

    assign active  = pend & mask;
    assign int_out = active;

    always_comb begin
        act_wide                = '0;
        act_wide[N_SRC-1:0]     = active;
        id_valid                = |active;
        id                      = irq_prio_id(act_wide);
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                IRQ_PEND: rdata = 32'(pend);
                IRQ_MASK: rdata = 32'(mask);
                IRQ_EDGE: rdata = 32'(edge_mode);
                default: begin
                    rdata[IRQ_ID_VALID] = id_valid;
                    rdata[3:0]          = id;
                end
            endcase
        end
    end

    assign unused_bits = ^{wdata, addr[1:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  irq_in;
    logic        sel;
    logic [3:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  int_out;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference state: registers as the software sees them, plus the history of
    // sampled request vectors (index 0 = most recent clock edge).
    logic [5:0] m_pend;
    logic [5:0] m_mask;
    logic [5:0] m_edge;
    logic [5:0] hist[$];

    irq_ctrl #(.N_SRC(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .sel     (sel),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_out (int_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_mask = '0;
        m_edge = '0;
        hist.delete();
        repeat (3) hist.push_back(6'h00);
    endtask

    function automatic logic [31:0] exp_id();
        logic [5:0] act;
        act = m_pend & m_mask;
        for (int i = 0; i < 6; i++)
            if (act[i]) return 32'h8000_0000 | 32'(i);
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic s, input logic [3:0] a);
        if (!s) return 32'h0;
        case (a[3:2])
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_edge);
            default: return exp_id();
        endcase
    endfunction

    // One rising edge of the controller, described source by source.
    task automatic model_edge(input logic [5:0] irq, input logic s, input logic [3:0] a,
                              input logic w, input logic [31:0] wd);
        logic [5:0] sync_now;
        logic [5:0] sync_before;
        logic [5:0] new_pend;
        logic       clear_req;
        sync_now    = hist[1];
        sync_before = hist[2];
        for (int i = 0; i < 6; i++) begin
            clear_req = s && w && (a[3:2] == 2'd0) && wd[i];
            if (m_edge[i]) begin
                if (sync_now[i] && !sync_before[i]) new_pend[i] = 1'b1;
                else if (clear_req)                 new_pend[i] = 1'b0;
                else                                new_pend[i] = m_pend[i];
            end else begin
                new_pend[i] = sync_now[i];
            end
        end
        if (s && w && a[3:2] == 2'd1) m_mask = wd[5:0];
        if (s && w && a[3:2] == 2'd2) m_edge = wd[5:0];
        m_pend = new_pend;
        hist.push_front(irq);
        void'(hist.pop_back());
    endtask

    task automatic cyc(input logic [5:0] irq, input logic s, input logic [3:0] a,
                       input logic w, input logic [31:0] wd);
        irq_in = irq;
        sel    = s;
        addr   = a;
        we     = w;
        wdata  = wd;
        #1;
        check("rdata", rdata, exp_rd(s, a));
        @(posedge clk);
        model_edge(irq, s, a, w, wd);
        #1;
        check("int_out", 32'(int_out), 32'(m_pend & m_mask));
        sel = 1'b0;
        we  = 1'b0;
    endtask

    task automatic idle(input logic [5:0] irq);
        cyc(irq, 1'b0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        cyc(irq_in, 1'b1, a, 1'b1, wd);
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [31:0] exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, rdata, exp);
        sel  = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        irq_in = 6'h3F;
        sel    = 1'b0;
        addr   = 4'h0;
        we     = 1'b0;
        wdata  = 32'h0;
        model_reset();

        // Reset held with all requests high
        repeat (2) @(posedge clk);
        #1;
        check("rst_int_out", 32'(int_out), 32'h0);
        peek("rst_pend", 4'h0, 32'h0);
        peek("rst_mask", 4'h4, 32'h0);
        peek("rst_edge", 4'h8, 32'h0);
        @(posedge clk);
        #1;
        peek("rst_id", 4'hC, 32'h0);
        rst = 1'b1;
        repeat (4) idle(6'h3F);
        check("post_rst_int", 32'(int_out), 32'h0);
        repeat (4) idle(6'h00);
        wr(4'h4, 32'h3F);
        wr(4'h8, 32'h3F);
        peek("mask_rd", 4'h4, 32'h3F);

        // Edge latch of a single-cycle pulse on source 2
        idle(6'h04);
        check("t2_e1", 32'(int_out), 32'h0);
        idle(6'h00);
        check("t2_e2", 32'(int_out), 32'h0);
        idle(6'h00);
        check("t2_e3", 32'(int_out), 32'h04);
        peek("t2_id", 4'hC, 32'h8000_0002);
        wr(4'h0, 32'h04);
        check("t2_clr", 32'(int_out), 32'h0);

        // Priority and write-1-to-clear
        idle(6'h12);
        idle(6'h00);
        idle(6'h00);
        peek("t3_id1", 4'hC, 32'h8000_0001);
        wr(4'h0, 32'h02);
        peek("t3_id4", 4'hC, 32'h8000_0004);
        wr(4'h0, 32'h10);
        peek("t3_id0", 4'hC, 32'h0);
        check("t3_int", 32'(int_out), 32'h0);

        // Set beats clear in the same cycle
        idle(6'h08);
        idle(6'h00);
        idle(6'h00);
        idle(6'h08);
        idle(6'h00);
        wr(4'h0, 32'h08);
        peek("t4_pend", 4'h0, 32'h08);
        wr(4'h0, 32'h08);
        peek("t4_clr", 4'h0, 32'h0);

        // Level mode ignores W1C and follows the request
        wr(4'h8, 32'h00);
        wr(4'h4, 32'h01);
        repeat (3) idle(6'h01);
        check("t5_high", 32'(int_out), 32'h01);
        cyc(6'h01, 1'b1, 4'h0, 1'b1, 32'h01);
        check("t5_w1c", 32'(int_out), 32'h01);
        idle(6'h00);
        idle(6'h00);
        check("t5_e2", 32'(int_out), 32'h01);
        idle(6'h00);
        check("t5_e3", 32'(int_out), 32'h00);

        // Masked pending survives and reasserts when unmasked
        wr(4'h8, 32'h20);
        wr(4'h4, 32'h00);
        idle(6'h20);
        idle(6'h00);
        idle(6'h00);
        check("t6_masked", 32'(int_out), 32'h0);
        peek("t6_pend", 4'h0, 32'h20);
        wr(4'h4, 32'h20);
        check("t6_unmask", 32'(int_out), 32'h20);

        // Unimplemented bits and read-only ID
        wr(4'h4, 32'hFFFF_FFFF);
        peek("mask_upper", 4'h4, 32'h3F);
        wr(4'hC, 32'hFFFF_FFFF);
        peek("id_ro", 4'hC, 32'h8000_0005);
        wr(4'h5, 32'h0000_0011);
        peek("addr_lsb", 4'h7, 32'h11);

        // Randomised traffic, with occasional asynchronous resets
        for (int k = 0; k < 400; k++) begin
            logic [3:0] ra;
            ra = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            cyc(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), ra,
                ($urandom_range(0, 2) == 0), $urandom);
            if (k == 150 || k == 300) begin
                rst  = 1'b0;
                sel  = 1'b1;
                addr = 4'h4;
                #1;
                check("midrst_int", 32'(int_out), 32'h0);
                check("midrst_rd", rdata, 32'h0);
                sel = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
